// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage load/store initiator.
// Size encoding matches the data RAM's Size port.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDone
    } state_e;

    typedef struct packed {
        logic        rw;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  rd;
    } req_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~addr_lo[0];
            SZ_WORD: return addr_lo == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, data-RAM and write-back signals of the MEM-stage access unit.
// master is the access unit itself; slave is the pipeline/RAM side.
interface mem_access_unit_if;

    logic        ex_valid;
    logic        ex_load;
    logic [1:0]  ex_size;
    logic        ex_signed;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [3:0]  ex_rd;

    logic [31:0] ram_data_out;
    logic        ram_enable;
    logic        ram_read_write;
    logic [31:0] ram_address;
    logic [31:0] ram_data_in;
    logic [1:0]  ram_size;

    logic        mem_stall;
    logic        mem_done;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [3:0]  wb_rd;
    logic        misalign_err;

    modport master (
        input  ex_valid, ex_load, ex_size, ex_signed, ex_addr, ex_store_data, ex_rd,
        input  ram_data_out,
        output ram_enable, ram_read_write, ram_address, ram_data_in, ram_size,
        output mem_stall, mem_done, wb_valid, wb_data, wb_rd, misalign_err
    );

    modport slave (
        output ex_valid, ex_load, ex_size, ex_signed, ex_addr, ex_store_data, ex_rd,
        output ram_data_out,
        input  ram_enable, ram_read_write, ram_address, ram_data_in, ram_size,
        input  mem_stall, mem_done, wb_valid, wb_data, wb_rd, misalign_err
    );

endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of right-aligned load data by access size.
module load_extend
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_raw,
    output logic [31:0] o_ext
);

    always_comb begin
        o_ext = i_raw;
        case (i_size)
            SZ_BYTE: o_ext = {{24{i_signed & i_raw[7]}}, i_raw[7:0]};
            SZ_HALF: o_ext = {{16{i_signed & i_raw[15]}}, i_raw[15:0]};
            default: o_ext = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: sequences the data RAM's level-triggered
// Enable through SETUP/ACCESS/DONE and stalls the pipeline meanwhile.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter int unsigned ADDR_LIMIT    = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_access_unit_if.master    bus
);

    localparam int unsigned    CntW    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 1);

    state_e          r_state;
    state_e          w_state_next;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;
    req_t            r_req;
    req_t            w_req_in;

    logic            r_ram_enable;
    logic            r_mem_done;
    logic            r_wb_valid;
    logic            r_misalign;
    logic [31:0]     r_wb_data;

    logic [32:0]     w_end;
    logic            w_legal;
    logic            w_accept;
    logic            w_reject;
    logic            w_last;
    logic [31:0]     w_ext;

    // 33-bit sum so an address near 2^32 cannot wrap back into range
    assign w_end    = {1'b0, bus.ex_addr} + 33'(size_bytes(bus.ex_size));
    assign w_legal  = (bus.ex_size != SZ_ILLEGAL)
                    && is_aligned(bus.ex_size, bus.ex_addr[1:0])
                    && (w_end <= 33'(ADDR_LIMIT));
    assign w_accept = (r_state == StIdle) && bus.ex_valid && w_legal;
    assign w_reject = (r_state == StIdle) && bus.ex_valid && !w_legal;
    assign w_last   = (r_state == StAccess) && (r_cnt == CntLast);

    assign w_req_in = '{
        rw:   bus.ex_load ? RW_READ : RW_WRITE,
        size: bus.ex_size,
        sgn:  bus.ex_signed,
        addr: bus.ex_addr,
        data: bus.ex_store_data,
        rd:   bus.ex_rd
    };

    load_extend u_load_extend (
        .i_size   (r_req.size),
        .i_signed (r_req.sgn),
        .i_raw    (bus.ram_data_out),
        .o_ext    (w_ext)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StSetup;
                end
            end
            StSetup: begin
                w_state_next = StAccess;
                w_cnt_next   = '0;
            end
            StAccess: begin
                if (r_cnt == CntLast) begin
                    w_state_next = StDone;
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_req        <= '0;
            r_ram_enable <= 1'b0;
            r_mem_done   <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_misalign   <= 1'b0;
            r_wb_data    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            // Outputs are decoded from the next state so they come straight off flops
            r_ram_enable <= (w_state_next == StAccess);
            r_mem_done   <= (w_state_next == StDone);
            r_wb_valid   <= (w_state_next == StDone) && (r_req.rw == RW_READ);
            r_misalign   <= w_reject;
            if (w_accept) begin
                r_req <= w_req_in;
            end
            if (w_last && (r_req.rw == RW_READ)) begin
                r_wb_data <= w_ext;
            end
        end
    end

    assign bus.ram_enable     = r_ram_enable;
    assign bus.ram_read_write = r_req.rw;
    assign bus.ram_address    = r_req.addr;
    assign bus.ram_data_in    = r_req.data;
    assign bus.ram_size       = r_req.size;

    assign bus.mem_stall    = w_accept || (r_state == StSetup) || (r_state == StAccess);
    assign bus.mem_done     = r_mem_done;
    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_rd        = r_req.rd;
    assign bus.misalign_err = r_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a byte RAM model behind instance 0
// (ACCESS_CYCLES=1) and a fixed read value behind instance 1 (ACCESS_CYCLES=3).
module tb_mem_access_unit;
    import mem_pkg::*;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        ex_valid;
    logic        ex_load;
    logic [1:0]  ex_size;
    logic        ex_signed;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [3:0]  ex_rd;

    int          cyc;
    int          n_checks;
    int          n_errors;
    sb_t         exp_q[$];

    mem_access_unit_if if0 ();
    mem_access_unit_if if1 ();

    mem_access_unit #(.ACCESS_CYCLES(1), .ADDR_LIMIT(256)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.master)
    );

    mem_access_unit #(.ACCESS_CYCLES(3), .ADDR_LIMIT(256)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.master)
    );

    assign if0.ex_valid      = ex_valid & ~sel;
    assign if1.ex_valid      = ex_valid & sel;
    assign if0.ex_load       = ex_load;
    assign if1.ex_load       = ex_load;
    assign if0.ex_size       = ex_size;
    assign if1.ex_size       = ex_size;
    assign if0.ex_signed     = ex_signed;
    assign if1.ex_signed     = ex_signed;
    assign if0.ex_addr       = ex_addr;
    assign if1.ex_addr       = ex_addr;
    assign if0.ex_store_data = ex_store_data;
    assign if1.ex_store_data = ex_store_data;
    assign if0.ex_rd         = ex_rd;
    assign if1.ex_rd         = ex_rd;
    assign if1.ram_data_out  = 32'h1234_8001;

    logic        w_stall, w_en, w_done, w_wbv, w_err;
    logic [31:0] w_wbd;
    logic [3:0]  w_wbrd;
    assign w_stall = sel ? if1.mem_stall    : if0.mem_stall;
    assign w_en    = sel ? if1.ram_enable   : if0.ram_enable;
    assign w_done  = sel ? if1.mem_done     : if0.mem_done;
    assign w_wbv   = sel ? if1.wb_valid     : if0.wb_valid;
    assign w_err   = sel ? if1.misalign_err : if0.misalign_err;
    assign w_wbd   = sel ? if1.wb_data      : if0.wb_data;
    assign w_wbrd  = sel ? if1.wb_rd        : if0.wb_rd;

    // Little-endian byte RAM with level-triggered enable
    logic [7:0]  mem [256];
    logic [7:0]  ram_a;
    logic [31:0] ram_rdata;
    assign ram_a = if0.ram_address[7:0];

    always_comb begin
        ram_rdata = '0;
        case (if0.ram_size)
            SZ_BYTE: ram_rdata = {24'd0, mem[ram_a]};
            SZ_HALF: ram_rdata = {16'd0, mem[ram_a + 8'd1], mem[ram_a]};
            default: ram_rdata = {mem[ram_a + 8'd3], mem[ram_a + 8'd2],
                                  mem[ram_a + 8'd1], mem[ram_a]};
        endcase
    end
    assign if0.ram_data_out = ram_rdata;

    always @(posedge clk) begin
        if (if0.ram_enable && if0.ram_read_write) begin
            mem[ram_a] <= if0.ram_data_in[7:0];
            if (if0.ram_size != SZ_BYTE) mem[ram_a + 8'd1] <= if0.ram_data_in[15:8];
            if (if0.ram_size == SZ_WORD) begin
                mem[ram_a + 8'd2] <= if0.ram_data_in[23:16];
                mem[ram_a + 8'd3] <= if0.ram_data_in[31:24];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request and hold it until the unit drops mem_stall; wb results
    // are popped from the scoreboard as they appear.
    task automatic run_req(input logic load, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [3:0] rd, output int n_stall, output int n_en,
                           output int n_done, output int n_wb, output int wb_k,
                           output int wb_cyc);
        bit  finished;
        sb_t e;
        finished = 1'b0;
        n_stall  = 0;
        n_en     = 0;
        n_done   = 0;
        n_wb     = 0;
        wb_k     = -1;
        wb_cyc   = -1;
        @(posedge clk);
        #1;
        ex_load = load; ex_size = size; ex_signed = sgn;
        ex_addr = addr; ex_store_data = sdata; ex_rd = rd; ex_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (w_en) n_en++;
            if (w_done) n_done++;
            if (w_wbv) begin
                n_wb++;
                wb_k   = k;
                wb_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_wb", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_data", w_wbd, e.data);
                    check("wb_rd", 32'(w_wbrd), 32'(e.rd));
                end
            end
            if (!w_stall) begin
                finished = 1'b1;
                break;
            end
            n_stall++;
        end
        check("req_timeout", 32'(finished), 32'd1);
    endtask

    task automatic idle_req();
        @(posedge clk);
        #1 ex_valid = 1'b0;
    endtask

    int          ns, ne, nd, nw, wk, wc, wc1;
    logic [1:0]  ill_sz [5];
    logic [31:0] ill_ad [5];

    initial begin
        rst_n = 1'b0; sel = 1'b0; ex_valid = 1'b0; ex_load = 1'b0; ex_size = 2'b00;
        ex_signed = 1'b0; ex_addr = '0; ex_store_data = '0; ex_rd = '0;
        n_checks = 0; n_errors = 0;
        ill_sz = '{SZ_HALF, SZ_ILLEGAL, SZ_WORD, SZ_WORD, SZ_HALF};
        ill_ad = '{32'h23, 32'h0, 32'hFE, 32'h100, 32'hFF};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ram_enable", 32'(if0.ram_enable), 32'd0);
        check("rst_ram_rw", 32'(if0.ram_read_write), 32'd0);
        check("rst_mem_stall", 32'(if0.mem_stall), 32'd0);
        check("rst_mem_done", 32'(if0.mem_done), 32'd0);
        check("rst_wb_valid", 32'(if0.wb_valid), 32'd0);
        check("rst_misalign", 32'(if0.misalign_err), 32'd0);
        check("rst_ram_address", if0.ram_address, 32'd0);
        check("rst_ram_data_in", if0.ram_data_in, 32'd0);
        check("rst_wb_data", if0.wb_data, 32'd0);
        check("rst_ram_size", 32'(if0.ram_size), 32'd0);
        check("rst_wb_rd", 32'(if0.wb_rd), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'd0, ns, ne, nd, nw, wk, wc);
        idle_req();
        check("sw_stall_cycles", 32'(ns), 32'd3);
        check("sw_enable_cycles", 32'(ne), 32'd1);
        check("sw_mem_done", 32'(nd), 32'd1);
        check("sw_no_wb", 32'(nw), 32'd0);

        exp_q.push_back('{rd: 4'd3, data: 32'hDEAD_BEEF});
        run_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 4'd3, ns, ne, nd, nw, wk, wc);
        idle_req();
        check("lw_enable_cycles", 32'(ne), 32'd1);
        check("lw_wb_count", 32'(nw), 32'd1);
        check("lw_latency", 32'(wk), 32'd3);
        check("lw_mem_done", 32'(nd), 32'd1);

        run_req(1'b0, SZ_BYTE, 1'b0, 32'h21, 32'hAAAA_AA80, 4'd0, ns, ne, nd, nw, wk, wc);
        idle_req();
        run_req(1'b0, SZ_BYTE, 1'b0, 32'hFF, 32'h0000_005A, 4'd0, ns, ne, nd, nw, wk, wc);
        idle_req();
        check("sb_top_byte_stall", 32'(ns), 32'd3);

        // Back-to-back loads: second request presented right after the first's DONE
        exp_q.push_back('{rd: 4'd5, data: 32'hFFFF_FF80});
        run_req(1'b1, SZ_BYTE, 1'b1, 32'h21, 32'h0, 4'd5, ns, ne, nd, nw, wk, wc1);
        check("b2b_first_wb", 32'(nw), 32'd1);
        exp_q.push_back('{rd: 4'd6, data: 32'h0000_0080});
        run_req(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h0, 4'd6, ns, ne, nd, nw, wk, wc);
        idle_req();
        check("b2b_second_wb", 32'(nw), 32'd1);
        check("b2b_spacing", 32'(wc - wc1), 32'd4);

        exp_q.push_back('{rd: 4'd10, data: 32'h0000_005A});
        run_req(1'b1, SZ_BYTE, 1'b0, 32'hFF, 32'h0, 4'd10, ns, ne, nd, nw, wk, wc);
        idle_req();
        check("lb_top_wb", 32'(nw), 32'd1);

        for (int i = 0; i < 5; i++) begin
            run_req(1'b1, ill_sz[i], 1'b0, ill_ad[i], 32'h0, 4'd1, ns, ne, nd, nw, wk, wc);
            check("ill_stall", 32'(ns), 32'd0);
            check("ill_enable", 32'(ne), 32'd0);
            idle_req();
            @(negedge clk);
            check("ill_misalign", 32'(w_err), 32'd1);
            check("ill_done", 32'(w_done), 32'd0);
            check("ill_wb", 32'(w_wbv), 32'd0);
            check("ill_enable_after", 32'(w_en), 32'd0);
            @(negedge clk);
            check("ill_misalign_pulse", 32'(w_err), 32'd0);
        end

        // Reset while the RAM is enabled
        @(posedge clk);
        #1;
        ex_load = 1'b1; ex_size = SZ_WORD; ex_signed = 1'b0; ex_addr = 32'h10; ex_rd = 4'd7;
        ex_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_enable_pre", 32'(w_en), 32'd1);
        rst_n = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_enable", 32'(w_en), 32'd0);
        check("rst_mid_stall", 32'(w_stall), 32'd0);
        check("rst_mid_done", 32'(w_done), 32'd0);
        check("rst_mid_wb", 32'(w_wbv), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_wb_after", 32'(w_wbv), 32'd0);
        check("rst_mid_done_after", 32'(w_done), 32'd0);

        exp_q.push_back('{rd: 4'd8, data: 32'hDEAD_BEEF});
        run_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 4'd8, ns, ne, nd, nw, wk, wc);
        idle_req();
        check("post_rst_wb", 32'(nw), 32'd1);

        sel = 1'b1;
        exp_q.push_back('{rd: 4'd9, data: 32'hFFFF_8001});
        run_req(1'b1, SZ_HALF, 1'b1, 32'h40, 32'h0, 4'd9, ns, ne, nd, nw, wk, wc);
        idle_req();
        check("ac3_stall_cycles", 32'(ns), 32'd5);
        check("ac3_enable_cycles", 32'(ne), 32'd3);
        check("ac3_latency", 32'(wk), 32'd5);
        check("ac3_wb_count", 32'(nw), 32'd1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store initiator for the pipelined core. It takes one memory request per instruction from the EX/MEM pipeline register and sequences `data_ram256x8`'s level-triggered Enable/ReadWrite port through a setup/access/done handshake. It sign- or zero-extends load data for the MEM/WB register and stalls the upstream pipeline while an access is in flight.

## Interface
Parameters:
- ACCESS_CYCLES, 1: number of cycles ram_enable is held high per access (≥1).
- ADDR_LIMIT, 256: bytes of data RAM; a request with addr + bytes > ADDR_LIMIT is out of range.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ex_valid  in  1  request present; request fields must stay stable while mem_stall=1.
- ex_load  in  1  1=load, 0=store.
- ex_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- ex_signed  in  1  sign-extend loads (ignored for word and stores).
- ex_addr  in  32  byte address.
- ex_store_data  in  32  store data, right-aligned.
- ex_rd  in  4  destination register tag, passed to wb_rd.
- ram_data_out  in  32  DataOut from data RAM.
- ram_enable  out  1  RAM Enable.
- ram_read_write  out  1  1=write, 0=read (RAM convention).
- ram_address  out  32  RAM address.
- ram_data_in  out  32  RAM DataIn.
- ram_size  out  2  RAM Size, same encoding as ex_size.
- mem_stall  out  1  freeze IF..EX/MEM; to the hazard unit.
- mem_done  out  1  one-cycle pulse when any access completes.
- wb_valid  out  1  one-cycle pulse with load result.
- wb_data  out  32  extended load data.
- wb_rd  out  4  tag of completed load.
- misalign_err  out  1  one-cycle pulse when a request is rejected.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - ex_valid=1 and the request is legal: latch all ex_* fields, go to SETUP.
  - ex_valid=1 and the request is illegal (misaligned half at odd addr, misaligned word at addr[1:0]≠0, size 11, or out of range): no RAM activity; next cycle misalign_err=1, mem_done=0, wb_valid=0; stay in IDLE.
- SETUP: drive ram_address/ram_size/ram_read_write/ram_data_in from the latched request with ram_enable=0; go to ACCESS next cycle. This guarantees a 0→1 Enable edge.
- ACCESS: ram_enable=1 with all fields held. A counter runs 0..ACCESS_CYCLES-1. On the last count, loads capture ram_data_out into the result register; go to DONE.
- DONE: ram_enable=0; mem_done=1. For loads, also wb_valid=1, wb_rd=latched rd, wb_data=extended result. No request is accepted in DONE. Go to IDLE.
- Load extension:
  - byte: data[7:0], bits 31:8 = ex_signed ? data[7] : 0.
  - half: data[15:0], bits 31:16 = ex_signed ? data[15] : 0.
  - word: unchanged.
- Stores pass ex_store_data unmodified; the RAM truncates by size.
- mem_stall = (IDLE ∧ ex_valid ∧ legal) ∨ SETUP ∨ ACCESS (combinational). It is low in DONE, so the pipeline advances at the end of DONE.
- Reset (any state, including mid-ACCESS): next state IDLE; all outputs are 0 from the following cycle. A store whose Enable edge already occurred is not undone.
- Reset values: ram_enable, ram_read_write, mem_stall, mem_done, wb_valid, misalign_err = 0; ram_address, ram_data_in, wb_data = 0; ram_size = 00; wb_rd = 0.

## Timing
- Request accepted at edge E0 (IDLE, legal). SETUP runs E0→E1. ACCESS runs E1→E1+ACCESS_CYCLES. DONE runs during the following cycle.
- Load-use latency with ACCESS_CYCLES=1: wb_valid is high in cycle 3 after acceptance (cycle 0).
- Throughput: one access per ACCESS_CYCLES+3 cycles. Back-to-back requests see the second request accepted in the cycle after DONE.
- Illegal request: misalign_err in the cycle after the request; mem_stall never rises.
- RAM outputs are registered and glitch-free; ram_enable goes high only in ACCESS.

## Structure
- Shared package mem_pkg:
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - RW_READ=0, RW_WRITE=1.
  - state enum for the FSM.
- Sub-module load_extend: combinational (size, signed, raw[31:0]) → ext[31:0]. Reused by the verification model.
- The top level holds the FSM, access counter, request latch, and legality check.

## Test plan
- Word store to 0x10 with 0xDEADBEEF, then word load from 0x10 with rd=3: ram_enable pulses high exactly 1 cycle each; wb_valid 3 cycles after acceptance with wb_data=0xDEADBEEF, wb_rd=3.
- Byte 0x80 stored at 0x21; load signed → 0xFFFFFF80; load unsigned → 0x00000080.
- Halfword load with ex_addr=0x23 → misalign_err pulse next cycle; ram_enable stays 0; mem_stall stays 0. Same for size=11 and for a word at 0xFE (out of range).
- ACCESS_CYCLES=3, halfword 0x8001 signed load → ram_enable high 3 cycles; mem_stall high 5 cycles; wb_data=0xFFFF8001.
- rst_n low during ACCESS → IDLE next edge; ram_enable, mem_stall 0; no wb_valid or mem_done; the next request completes normally.
- Two back-to-back loads held by the stall → exactly two wb_valid pulses, 4 cycles apart (ACCESS_CYCLES=1), correct rd tags.
